lcd_ctrl: RTL

Memory-mapped HD44780-style character-LCD controller that accepts CPU store cycles as a bus responder and drives the 11-bit lcd pin bundle with correct E-strobe timing.
- Software writes {RS, DB} entries into a 4-deep command FIFO.
- A timing FSM plays each entry out as setup / E-pulse / hold / execution-wait, so software never bit-bangs E.
- Sits on the 62.5 MHz CPU clock, selected by the top-level address decode of 0xff0c.
- Replaces the raw lcd register; the status word is muxed into the CPU read-data path.

---
 rtl/lcd_ctrl_pkg.sv | 25 ++
 rtl/lcd_fifo.sv | 45 ++++
 rtl/lcd_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared encodings for the character-LCD controller: FSM states, lcd pin
// positions, the queued entry layout and the long-command decode.
package lcd_ctrl_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_PULSE = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;

   localparam int LCD_E  = 10;
   localparam int LCD_RS = 9;
   localparam int LCD_RW = 8;

   typedef struct packed {
      logic       rs;
      logic [7:0] db;
   } lcd_entry_t;

   // Clear display / return home need the long execution wait.
   function automatic logic is_long_cmd(input lcd_entry_t e);
      return !e.rs && (e.db == 8'h01 || e.db == 8'h02 || e.db == 8'h03);
   endfunction

endpackage

// File: rtl/lcd_fifo.sv
// 4-entry command FIFO. A push into a full FIFO is taken only when a pop
// frees a slot on the same edge; the caller detects drops from full/pop.
module lcd_fifo
   import lcd_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  lcd_entry_t din,
   output lcd_entry_t dout,
   output logic       full,
   output logic       empty,
   output logic [2:0] count
);

   lcd_entry_t mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic       do_push, do_pop;

   assign full    = (count == 3'd4);
   assign empty   = (count == 3'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array; no reset needed, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally at 2 bits; count tracks occupancy 0..4.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 2'd1;
         if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b0, do_push} - {2'b0, do_pop};
      end
   end

endmodule

// File: rtl/lcd_ctrl.sv
// Memory-mapped HD44780 controller: CPU stores queue {RS,DB} entries and a
// timing FSM plays each one out as setup / E pulse / hold / execution wait.
module lcd_ctrl
   import lcd_ctrl_pkg::*;
#(
   parameter int SETUP_CYC = 4,
   parameter int PULSE_CYC = 16,
   parameter int HOLD_CYC  = 4,
   parameter int EXEC_CYC  = 2500,
   parameter int LONG_CYC  = 102500,
   parameter int CW        = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        memwrite,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [10:0] lcd
);

   logic          wr_cyc, push, clr_ovf, pop;
   logic          full, empty, overflow, busy;
   logic [2:0]    count;
   logic [2:0]    state;
   logic [CW-1:0] dly;
   lcd_entry_t    fifo_in, head, ent;
   logic          unused_wdata;

   assign wr_cyc       = cs && memwrite;
   assign push         = wr_cyc && !writedata[31];
   assign clr_ovf      = wr_cyc && writedata[31];
   assign fifo_in      = '{rs: writedata[8], db: writedata[7:0]};
   assign pop          = (state == ST_IDLE) && !empty;
   assign unused_wdata = ^writedata[30:9];

   lcd_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (fifo_in),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Sticky overflow: set when a push finds no free slot, cleared by command.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                     overflow <= 1'b0;
      else if (clr_ovf)               overflow <= 1'b0;
      else if (push && full && !pop)  overflow <= 1'b1;
   end

   // Timing FSM; lcd is driven only from here so the pins are fully registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         dly   <= '0;
         ent   <= '0;
         lcd   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (pop) begin
               ent   <= head;
               lcd   <= {1'b0, head.rs, 1'b0, head.db};
               dly   <= CW'(SETUP_CYC - 1);
               state <= ST_SETUP;
            end
            ST_SETUP: if (dly == '0) begin
               lcd[LCD_E] <= 1'b1;
               dly        <= CW'(PULSE_CYC - 1);
               state      <= ST_PULSE;
            end else dly <= dly - 1'b1;
            ST_PULSE: if (dly == '0) begin
               lcd[LCD_E] <= 1'b0;
               dly        <= CW'(HOLD_CYC - 1);
               state      <= ST_HOLD;
            end else dly <= dly - 1'b1;
            ST_HOLD: if (dly == '0) begin
               dly   <= is_long_cmd(ent) ? CW'(LONG_CYC - 1) : CW'(EXEC_CYC - 1);
               state <= ST_WAIT;
            end else dly <= dly - 1'b1;
            ST_WAIT: if (dly == '0) state <= ST_IDLE;
                     else dly <= dly - 1'b1;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy     = (state != ST_IDLE) || (count != 3'd0);
   assign readdata = {25'd0, count, overflow, 1'b0, full, busy};

endmodule
